// File: rtl/alu_ctrl.sv
// alu_ctrl: button-driven op-select register feeding a registered WIDTH-bit ALU.
// Optional macro ALU_DEBOUNCE_EN inserts per-button debouncers (DB_CYCLES).
module alu_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             big_up_mode,
    input  logic             big_down_mode,
    input  logic             small_up_mode,
    input  logic             small_down_mode,
    output logic [2:0]       mode,
    output logic             mode_chg,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             of,
    output logic             cf
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // Button bit positions, also the priority order (lowest index wins).
    localparam int BD = 0;
    localparam int BU = 1;
    localparam int SU = 2;
    localparam int SD = 3;

    localparam int M = WIDTH - 1;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("alu_ctrl: WIDTH must be 2..32");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("alu_ctrl: DB_CYCLES must be >= 1");
    end

    logic [3:0] btn;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] lvl;
    logic [3:0] prev_q;
    logic [3:0] pulse;

    assign btn = {small_down_mode, small_up_mode,
                  big_up_mode, big_down_mode};

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef ALU_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [3:0]    db_q;
    logic [3:0]    db_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    // Flip the debounced level once the synced level disagrees for DB_CYCLES clocks.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce level and run-length counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lvl = db_q;
`else
    assign lvl = sync2_q;
`endif

    // Previous conditioned level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign pulse = lvl & ~prev_q;

    logic [2:0] mode_q;
    logic [2:0] mode_d;
    logic [2:0] step;
    logic       chg_q;
    logic       chg_d;

    // Pick only the highest-priority pulse; the rest are dropped.
    always_comb begin
        step  = 3'd0;
        chg_d = 1'b1;
        if (pulse[BD]) begin
            step = 3'b110;
        end else if (pulse[BU]) begin
            step = 3'b010;
        end else if (pulse[SU]) begin
            step = 3'b001;
        end else if (pulse[SD]) begin
            step = 3'b111;
        end else begin
            chg_d = 1'b0;
        end
        mode_d = mode_q + step;
    end

    // Mode register (wraps modulo 8) and its change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 3'd0;
            chg_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            chg_q  <= chg_d;
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             slt;
    logic [WIDTH-1:0] res_d;
    logic             cf_d;
    logic             of_d;
    logic             zf_d;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign slt  = $signed(a) < $signed(b);

    // Combinational ALU selected by the current mode.
    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        of_d  = 1'b0;
        unique case (mode_q)
            OP_ADD: begin
                res_d = sum[M:0];
                cf_d  = sum[WIDTH];
                of_d  = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                res_d = diff[M:0];
                cf_d  = diff[WIDTH];
                of_d  = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt};
            OP_SHL: begin
                res_d = {a[M-1:0], 1'b0};
                cf_d  = a[M];
            end
            OP_SHR: begin
                res_d = {1'b0, a[M:1]};
                cf_d  = a[0];
            end
        endcase
        zf_d = (res_d == '0);
    end

    logic [WIDTH-1:0] res_q;
    logic             zf_q;
    logic             of_q;
    logic             cf_q;

    // Result and flag registers, one clock behind the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            zf_q  <= 1'b0;
            of_q  <= 1'b0;
            cf_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            zf_q  <= zf_d;
            of_q  <= of_d;
            cf_q  <= cf_d;
        end
    end

    assign mode     = mode_q;
    assign mode_chg = chg_q;
    assign result   = res_q;
    assign zf       = zf_q;
    assign of       = of_q;
    assign cf       = cf_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl with a cycle-level reference model.
// Timing expectations follow ALU_DEBOUNCE_EN when it is defined (DB_CYCLES=4).
module tb_alu_ctrl;

    localparam int W  = 4;
    localparam int DB = 4;
`ifdef ALU_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT    = 3 + (DEB ? DB : 0);
    localparam int HOLD   = LAT + 2;
    localparam int SETTLE = LAT + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         big_up_mode = 1'b0;
    logic         big_down_mode = 1'b0;
    logic         small_up_mode = 1'b0;
    logic         small_down_mode = 1'b0;
    logic [2:0]   mode;
    logic         mode_chg;
    logic [W-1:0] result;
    logic         zf, of, cf;

    alu_ctrl #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .big_up_mode(big_up_mode), .big_down_mode(big_down_mode),
        .small_up_mode(small_up_mode), .small_down_mode(small_down_mode),
        .mode(mode), .mode_chg(mode_chg), .result(result),
        .zf(zf), .of(of), .cf(cf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode = 0;
    bit m_chg = 0;
    int m_res = 0;
    bit m_z = 0, m_o = 0, m_c = 0;
    bit sp1 [4];
    bit sp2 [4];
    bit c1 [4];
    bit c2 [4];
    bit dlev [4];
    int run [4];
    bit lv [4];
    bit ev [4];
    bit cn;
    int steps [4] = '{-2, 2, 1, -1};

    task automatic model_alu(input int op, input longint ua,
                             input longint ub);
        longint half, full, sa, sb, r, sr;
        half = longint'(1) << (W - 1);
        full = longint'(1) << W;
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        m_c = 0;
        m_o = 0;
        r = 0;
        case (op)
            0: begin
                r = ua + ub; m_c = (r >= full);
                sr = sa + sb; m_o = (sr >= half) || (sr < -half);
            end
            1: begin
                r = ua - ub; m_c = (ua < ub);
                sr = sa - sb; m_o = (sr >= half) || (sr < -half);
            end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (sa < sb) ? 1 : 0;
            6: begin r = ua * 2; m_c = (ua >= half); end
            default: begin r = ua / 2; m_c = (ua % 2) == 1; end
        endcase
        r = ((r % full) + full) % full;
        m_res = int'(r);
        m_z = (m_res == 0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_chg = 0; m_res = 0;
            m_z = 0; m_o = 0; m_c = 0;
            for (int i = 0; i < 4; i++) begin
                sp1[i] = 0; sp2[i] = 0; c1[i] = 0; c2[i] = 0;
                dlev[i] = 0; run[i] = 0;
            end
        end else begin
            model_alu(m_mode, longint'(a), longint'(b));
            lv[0] = big_down_mode;
            lv[1] = big_up_mode;
            lv[2] = small_up_mode;
            lv[3] = small_down_mode;
            for (int i = 0; i < 4; i++) begin
                if (!DEB) begin
                    cn = sp1[i];
                end else begin
                    if (sp2[i] != dlev[i]) begin
                        run[i]++;
                        if (run[i] == DB) begin
                            dlev[i] = sp2[i];
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                    cn = dlev[i];
                end
                ev[i] = c1[i] & ~c2[i];
                c2[i] = c1[i];
                c1[i] = cn;
                sp2[i] = sp1[i];
                sp1[i] = lv[i];
            end
            m_chg = 0;
            for (int i = 0; i < 4; i++) begin
                if (ev[i] && !m_chg) begin
                    m_mode = (m_mode + steps[i] + 8) % 8;
                    m_chg = 1;
                end
            end
        end
    end

    // Compare every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("cyc_mode", 32'(mode), 32'(m_mode));
        chk("cyc_mode_chg", 32'(mode_chg), 32'(m_chg));
        chk("cyc_result", 32'(result), 32'(m_res));
        chk("cyc_zf", 32'(zf), 32'(m_z));
        chk("cyc_of", 32'(of), 32'(m_o));
        chk("cyc_cf", 32'(cf), 32'(m_c));
        if (mode_chg === 1'b1) chg_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: big_down_mode = v;
            1: big_up_mode = v;
            2: small_up_mode = v;
            default: small_down_mode = v;
        endcase
    endtask

    task automatic press(input int idx);
        @(negedge clk);
        set_btn(idx, 1'b1);
        repeat (HOLD) @(negedge clk);
        set_btn(idx, 1'b0);
        repeat (SETTLE) @(negedge clk);
    endtask

    logic [W-1:0] va [6] = '{4'h7, 4'h8, 4'hF, 4'h0, 4'h5, 4'h9};
    logic [W-1:0] vb [6] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h5, 4'hC};
    int c0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_chg", 32'(mode_chg), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", {29'b0, zf, of, cf}, 0);

        // ADD signed overflow: 7+1
        rst = 1'b0;
        a = 4'h7; b = 4'h1;
        @(posedge clk); #1;
        chk("add_res", 32'(result), 32'h8);
        chk("add_of", 32'(of), 1);
        chk("add_cf", 32'(cf), 0);
        chk("add_zf", 32'(zf), 0);
        chk("add_model", 32'(m_res), 32'h8);

        press(2);
        chk("to_sub", 32'(mode), 1);
        a = 4'h3; b = 4'h5;
        @(posedge clk); #1;
        chk("sub_res", 32'(result), 32'hE);
        chk("sub_cf", 32'(cf), 1);
        chk("sub_of", 32'(of), 0);
        @(negedge clk);
        a = 4'h5; b = 4'h5;
        @(posedge clk); #1;
        chk("sub0_res", 32'(result), 0);
        chk("sub0_zf", 32'(zf), 1);
        chk("sub0_cf", 32'(cf), 0);

        // Sweep every op with a few vectors (model checks each cycle).
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                a = va[k]; b = vb[k];
            end
            press(2);
        end
        chk("sweep_mode", 32'(mode), 1);

        press(0);
        chk("1_bigdown_7", 32'(mode), 7);
        chk("model_7", 32'(m_mode), 7);

        // Held small_up: exactly one step after LAT edges.
        c0 = chg_cnt;
        @(negedge clk);
        small_up_mode = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("hold_early", 32'(mode), 7);
        @(posedge clk);
        #1;
        chk("hold_wrap", 32'(mode), 0);
        chk("hold_pulse", 32'(mode_chg), 1);
        repeat (20 - LAT) @(negedge clk);
        small_up_mode = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("hold_once", 32'(chg_cnt - c0), 1);
        chk("hold_final", 32'(mode), 0);

        // Simultaneous big_up and small_down from 3.
        press(1);
        press(2);
        chk("to_3", 32'(mode), 3);
        c0 = chg_cnt;
        @(negedge clk);
        big_up_mode = 1'b1; small_down_mode = 1'b1;
        repeat (HOLD) @(negedge clk);
        big_up_mode = 1'b0; small_down_mode = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("prio_mode", 32'(mode), 5);
        chk("prio_once", 32'(chg_cnt - c0), 1);
        press(0);
        press(0);
        chk("to_1", 32'(mode), 1);
        press(0);
        chk("bd_wrap", 32'(mode), 7);
        press(3);
        chk("to_6", 32'(mode), 6);

        // Asynchronous reset mid-cycle.
        a = 4'h3; b = 4'h0;
        @(posedge clk); #1;
        chk("shl_res", 32'(result), 6);
        #2 rst = 1'b1;
        #1;
        chk("arst_mode", 32'(mode), 0);
        chk("arst_chg", 32'(mode_chg), 0);
        chk("arst_result", 32'(result), 0);
        chk("arst_flags", {29'b0, zf, of, cf}, 0);

        // Button held through reset release counts as a press.
        @(negedge clk);
        small_up_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("rel_mode", 32'(mode), 1);
        chk("rel_chg", 32'(mode_chg), 1);
        @(negedge clk);
        small_up_mode = 1'b0;
        repeat (SETTLE) @(negedge clk);

        // Reset mid-press abandons the step.
        @(negedge clk);
        small_up_mode = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #2 small_up_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        c0 = chg_cnt;
        repeat (SETTLE) @(negedge clk);
        chk("abandon_mode", 32'(mode), 0);
        chk("abandon_chg", 32'(chg_cnt - c0), 0);

        // Two-cycle glitch: filtered only with debounce.
        c0 = chg_cnt;
        @(negedge clk);
        small_up_mode = 1'b1;
        repeat (2) @(negedge clk);
        small_up_mode = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("glitch_mode", 32'(mode), DEB ? 0 : 1);
        chk("glitch_chg", 32'(chg_cnt - c0), DEB ? 0 : 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
